// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore control FSM for a multi-cycle RV32I-subset datapath that shares one
// memory port for instructions and data. Every instruction runs through
// fetch / decode / execute / memory / writeback steps. The ALU, register file
// and memory are reused across these steps.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   instr         instruction register contents (opcode, funct3, funct7b5 used)
//   eq            ALU zero flag, consulted only for branches
//   mem_ready     memory completes the current access this cycle
//   pc_write, ir_write, reg_write, mem_req, mem_we   datapath enables
//   adr_src, alu_src_a, alu_src_b, alu_ctrl,
//   result_src, imm_src                              datapath mux selects
//   halted        illegal instruction trapped
//   state         current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  eq,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  adr_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            alu_ctrl,
    output logic [1:0]            result_src,
    output logic [2:0]            imm_src,
    output logic                  halted,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_LUI      = 4'd10,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    // Opcode/funct3 combinations the datapath can execute.
    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        logic ok;
        case (op)
            OP_R, OP_I: begin
                case (f3)
                    3'b000, 3'b010, 3'b110, 3'b111: ok = 1'b1;
                    default:                        ok = 1'b0;
                endcase
            end
            OP_LW, OP_SW: ok = (f3 == 3'b010);
            OP_BR:        ok = (f3 == 3'b000) || (f3 == 3'b001);
            OP_LUI:       ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ALU operation for R/I arithmetic; sub only when the caller allows it.
    function automatic logic [2:0] alu_from_f3(input logic [2:0] f3, input logic use_sub);
        logic [2:0] op;
        case (f3)
            3'b000:  op = use_sub ? 3'b001 : 3'b000;
            3'b010:  op = 3'b101;
            3'b110:  op = 3'b011;
            3'b111:  op = 3'b010;
            default: op = 3'b000;
        endcase
        return op;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        funct7b5_s;
    logic        pc_write_s;
    logic        ir_write_s;
    logic        reg_write_s;
    logic        mem_req_s;
    logic        mem_we_s;
    logic        halted_s;
    logic        unused_s;

    assign opcode_s   = instr[6:0];
    assign funct3_s   = instr[14:12];
    assign funct7b5_s = instr[30];
    assign unused_s   = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_next_s = state_r;
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        halted_s     = 1'b0;
        adr_src      = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_ctrl     = 3'b000;
        result_src   = 2'b00;
        imm_src      = 3'b000;
        case (state_r)
            S_FETCH: begin
                // PC + 4 is computed and written back directly from the ALU.
                mem_req_s  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // oldPC + B-immediate lands in ALUOut as the branch target.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
                if (!is_legal(opcode_s, funct3_s)) begin
                    state_next_s = S_HALT;
                end else begin
                    case (opcode_s)
                        OP_LW, OP_SW: state_next_s = S_MEMADR;
                        OP_R:         state_next_s = S_EXEC_R;
                        OP_I:         state_next_s = S_EXEC_I;
                        OP_BR:        state_next_s = S_BRANCH;
                        OP_LUI:       state_next_s = S_LUI;
                        default:      state_next_s = S_HALT;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (opcode_s == OP_SW) begin
                    imm_src      = 3'b001;
                    state_next_s = S_MEMWRITE;
                end else begin
                    imm_src      = 3'b000;
                    state_next_s = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_MEMWB;
                end else begin
                    state_next_s = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                result_src   = 2'b01;
                state_next_s = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEMWRITE;
                end
            end
            S_EXEC_R: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b00;
                alu_ctrl     = alu_from_f3(funct3_s, funct7b5_s);
                state_next_s = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                imm_src      = 3'b000;
                alu_ctrl     = alu_from_f3(funct3_s, 1'b0);
                state_next_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                result_src   = 2'b00;
                state_next_s = S_FETCH;
            end
            S_BRANCH: begin
                // rd1 - rd2 drives eq; ALUOut still holds the target.
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_ctrl   = 3'b001;
                result_src = 2'b00;
                if (funct3_s == 3'b000) begin
                    pc_write_s = eq;
                end else if (funct3_s == 3'b001) begin
                    pc_write_s = ~eq;
                end else begin
                    pc_write_s = 1'b0;
                end
                state_next_s = S_FETCH;
            end
            S_LUI: begin
                alu_src_a    = 2'b11;
                alu_src_b    = 2'b01;
                imm_src      = 3'b011;
                state_next_s = S_ALUWB;
            end
            S_HALT: begin
                halted_s     = 1'b1;
                state_next_s = S_HALT;
            end
            default: begin
                // Unused encodings trap on the next edge.
                state_next_s = S_HALT;
            end
        endcase
    end

    // Reset suppresses every write enable immediately, even mid-access.
    always_comb begin
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            halted    = 1'b0;
        end else begin
            pc_write  = pc_write_s;
            ir_write  = ir_write_s;
            reg_write = reg_write_s;
            mem_req   = mem_req_s;
            mem_we    = mem_we_s;
            halted    = halted_s;
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. Each step pushes the expected
// state / enable vector / halted flag into a scoreboard queue. The bench then
// pops that entry and compares it once the DUT outputs for that cycle settle.
// Individual mux selects are checked against constants at chosen points.
// Enable vector order: {pc_write, ir_write, reg_write, mem_req, mem_we}.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        eq;
    logic        mem_ready;
    logic        pc_write, ir_write, reg_write, mem_req, mem_we, adr_src, halted;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  alu_ctrl, imm_src;
    logic [3:0]  state;

    typedef struct packed {
        logic [3:0] st;
        logic [4:0] en;
        logic       hlt;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    multicycle_controller #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .eq         (eq),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .result_src (result_src),
        .imm_src    (imm_src),
        .halted     (halted),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [3:0] st, input logic [4:0] en, input logic hlt);
        exp_t e;
        e.st  = st;
        e.en  = en;
        e.hlt = hlt;
        sb_q.push_back(e);
    endtask

    // Let outputs settle, then compare against the oldest expectation.
    task automatic chk(input string tag);
        exp_t       e;
        logic [4:0] en_obs;
        #1;
        en_obs = {pc_write, ir_write, reg_write, mem_req, mem_we};
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: scoreboard empty, got state %0d", tag, state);
        end else begin
            e = sb_q.pop_front();
            total++;
            assert (state === e.st) else begin
                bad++;
                $error("FAIL %s state: got %0d want %0d", tag, state, e.st);
            end
            total++;
            assert (en_obs === e.en) else begin
                bad++;
                $error("FAIL %s enables: got %b want %b", tag, en_obs, e.en);
            end
            total++;
            assert (halted === e.hlt) else begin
                bad++;
                $error("FAIL %s halted: got %b want %b", tag, halted, e.hlt);
            end
        end
    endtask

    task automatic cyc(input logic mr, input logic e, input string tag);
        mem_ready = mr;
        eq        = e;
        chk(tag);
    endtask

    task automatic chkf(input string tag, input logic [2:0] got, input logic [2:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;
        eq        = 1'b0;
        instr     = 32'h0000_0000;
        #2;
        push(4'd0, 5'b00000, 1'b0); chk("reset_hold");
        tick();
        rst = 1'b0;

        // addi x1, x0, 5
        instr = 32'h0050_0093;
        push(4'd0, 5'b11010, 1'b0); cyc(1'b1, 1'b0, "addi_fetch"); tick();
        push(4'd1, 5'b00000, 1'b0); cyc(1'b1, 1'b0, "addi_decode"); tick();
        push(4'd7, 5'b00000, 1'b0); cyc(1'b1, 1'b0, "addi_exec");
        chkf("addi_srcb", {1'b0, alu_src_b}, 3'b001);
        chkf("addi_alu", alu_ctrl, 3'b000); tick();
        push(4'd8, 5'b00100, 1'b0); cyc(1'b1, 1'b0, "addi_wb");
        chkf("addi_rsrc", {1'b0, result_src}, 3'b000); tick();

        // lw x2, 0(x1): one fetch wait, then two wait states in MEMREAD
        instr = 32'h0000_A103;
        push(4'd0, 5'b00010, 1'b0); cyc(1'b0, 1'b0, "lw_fetch_wait"); tick();
        push(4'd0, 5'b11010, 1'b0); cyc(1'b1, 1'b0, "lw_fetch"); tick();
        push(4'd1, 5'b00000, 1'b0); cyc(1'b0, 1'b0, "lw_decode"); tick();
        push(4'd2, 5'b00000, 1'b0); cyc(1'b0, 1'b0, "lw_memadr");
        chkf("lw_imm", imm_src, 3'b000); tick();
        push(4'd3, 5'b00010, 1'b0); cyc(1'b0, 1'b0, "lw_wait1");
        chkf("lw_adr", {2'b00, adr_src}, 3'b001); tick();
        push(4'd3, 5'b00010, 1'b0); cyc(1'b0, 1'b0, "lw_wait2"); tick();
        push(4'd3, 5'b00010, 1'b0); cyc(1'b1, 1'b0, "lw_memread"); tick();
        push(4'd4, 5'b00100, 1'b0); cyc(1'b0, 1'b0, "lw_memwb");
        chkf("lw_rsrc", {1'b0, result_src}, 3'b001); tick();

        // bne taken (eq=0), then not taken (eq=1)
        instr = 32'hFE00_98E3;
        push(4'd0, 5'b11010, 1'b0); cyc(1'b1, 1'b0, "bne0_fetch"); tick();
        push(4'd1, 5'b00000, 1'b0); cyc(1'b1, 1'b1, "bne0_decode"); tick();
        push(4'd9, 5'b10000, 1'b0); cyc(1'b1, 1'b0, "bne0_branch");
        chkf("bne0_alu", alu_ctrl, 3'b001); tick();
        push(4'd0, 5'b11010, 1'b0); cyc(1'b1, 1'b0, "bne1_fetch"); tick();
        push(4'd1, 5'b00000, 1'b0); cyc(1'b1, 1'b0, "bne1_decode"); tick();
        push(4'd9, 5'b00000, 1'b0); cyc(1'b1, 1'b1, "bne1_branch"); tick();

        // sub x0, x1, x2 then add x0, x1, x2
        instr = 32'h4020_8033;
        push(4'd0, 5'b11010, 1'b0); cyc(1'b1, 1'b0, "sub_fetch"); tick();
        push(4'd1, 5'b00000, 1'b0); cyc(1'b1, 1'b0, "sub_decode"); tick();
        push(4'd6, 5'b00000, 1'b0); cyc(1'b1, 1'b0, "sub_exec");
        chkf("sub_alu", alu_ctrl, 3'b001); tick();
        push(4'd8, 5'b00100, 1'b0); cyc(1'b1, 1'b0, "sub_wb"); tick();
        instr = 32'h0020_8033;
        push(4'd0, 5'b11010, 1'b0); cyc(1'b1, 1'b0, "add_fetch"); tick();
        push(4'd1, 5'b00000, 1'b0); cyc(1'b1, 1'b0, "add_decode"); tick();
        push(4'd6, 5'b00000, 1'b0); cyc(1'b1, 1'b0, "add_exec");
        chkf("add_alu", alu_ctrl, 3'b000); tick();
        push(4'd8, 5'b00100, 1'b0); cyc(1'b1, 1'b0, "add_wb"); tick();

        // lui x1, 0x12345
        instr = 32'h1234_50B7;
        push(4'd0, 5'b11010, 1'b0); cyc(1'b1, 1'b0, "lui_fetch"); tick();
        push(4'd1, 5'b00000, 1'b0); cyc(1'b1, 1'b0, "lui_decode"); tick();
        push(4'd10, 5'b00000, 1'b0); cyc(1'b1, 1'b0, "lui_exec");
        chkf("lui_srca", {1'b0, alu_src_a}, 3'b011);
        chkf("lui_imm", imm_src, 3'b011); tick();
        push(4'd8, 5'b00100, 1'b0); cyc(1'b1, 1'b0, "lui_wb"); tick();

        // sw x2, 0(x1) aborted by reset while MEMWRITE waits
        instr = 32'h0020_A023;
        push(4'd0, 5'b11010, 1'b0); cyc(1'b1, 1'b0, "sw_fetch"); tick();
        push(4'd1, 5'b00000, 1'b0); cyc(1'b1, 1'b0, "sw_decode"); tick();
        push(4'd2, 5'b00000, 1'b0); cyc(1'b1, 1'b0, "sw_memadr");
        chkf("sw_imm", imm_src, 3'b001); tick();
        push(4'd5, 5'b00011, 1'b0); cyc(1'b0, 1'b0, "sw_memwrite");
        rst = 1'b1;
        push(4'd0, 5'b00000, 1'b0); chk("sw_async_rst");
        tick();
        rst = 1'b0;
        push(4'd0, 5'b00010, 1'b0); cyc(1'b0, 1'b0, "post_rst_fetch"); tick();

        // Illegal opcode traps and holds until reset
        instr = 32'h0000_007F;
        push(4'd0, 5'b11010, 1'b0); cyc(1'b1, 1'b0, "ill_fetch"); tick();
        push(4'd1, 5'b00000, 1'b0); cyc(1'b1, 1'b0, "ill_decode"); tick();
        for (int i = 0; i < 12; i++) begin
            push(4'd15, 5'b00000, 1'b1);
            cyc(1'b1, i[0], $sformatf("halt_%0d", i));
            tick();
        end
        rst = 1'b1;
        push(4'd0, 5'b00000, 1'b0); chk("halt_rst");
        tick();
        rst = 1'b0;
        push(4'd0, 5'b00010, 1'b0); cyc(1'b0, 1'b0, "halt_recover_fetch");

        total++;
        assert (sb_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences a multi-cycle RV32I-subset datapath over a single shared instruction/data memory port. Each instruction is split into fetch, decode, execute, memory and writeback steps, with the ALU, register file and memory reused across steps. The block sits beside the register file, ALU, sign-extender and PC register. It drives every enable and mux select they consume, and waits on a memory ready handshake.

## Interface
- DATA_WIDTH, 32, width of the instruction input; only bits listed below are decoded
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- instr  in  DATA_WIDTH  instruction register contents; uses [6:0] opcode, [14:12] funct3, [30] funct7b5
- eq  in  1  ALU equality flag (ALU result == 0)
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register load enable
- ir_write  out  1  instruction register load enable
- reg_write  out  1  register file write enable
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (valid only with mem_req)
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut register
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rd1, 11 zero
- alu_src_b  out  2  00 rd2, 01 ImmOp, 10 constant 4
- alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- result_src  out  2  00 ALUOut register, 01 memory read data, 10 ALU result (direct)
- imm_src  out  3  000 I, 001 S, 010 B, 011 U
- halted  out  1  illegal instruction trapped
- state  out  4  current state encoding (debug)

## Operation
- Supported instructions:
  - R-type 0110011: add/sub (f3 000), slt (010), or (110), and (111).
  - I-type 0010011: same funct3 set, never sub.
  - lw 0000011 f3 010; sw 0100011 f3 010.
  - beq/bne 1100011 f3 000/001.
  - lui 0110111.
- Any other opcode or funct3 is illegal.
- Defaults: all outputs 0 unless listed for a state.
- States and transitions:
  - FETCH(0): mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10. If mem_ready: ir_write=1, pc_write=1, go to DECODE; else stay.
  - DECODE(1): alu_src_a=01, alu_src_b=01, imm_src=010, add (branch target into ALUOut). Next state: lw/sw to MEMADR, R to EXEC_R, I to EXEC_I, branch to BRANCH, lui to LUI, illegal to HALT.
  - MEMADR(2): alu_src_a=10, alu_src_b=01, add, imm_src=000 for lw / 001 for sw. lw to MEMREAD, sw to MEMWRITE.
  - MEMREAD(3): mem_req=1, adr_src=1. Go to MEMWB on mem_ready, else stay.
  - MEMWB(4): reg_write=1, result_src=01, then FETCH.
  - MEMWRITE(5): mem_req=1, mem_we=1, adr_src=1. Go to FETCH on mem_ready, else stay.
  - EXEC_R(6): alu_src_a=10, alu_src_b=00, alu_ctrl decoded from funct3; f3 000 with funct7b5=1 selects sub. Then ALUWB.
  - EXEC_I(7): alu_src_a=10, alu_src_b=01, imm_src=000, alu_ctrl from funct3 (000 always add). Then ALUWB.
  - ALUWB(8): reg_write=1, result_src=00, then FETCH.
  - BRANCH(9): alu_src_a=10, alu_src_b=00, sub, result_src=00. pc_write = (f3==000 & eq) | (f3==001 & !eq). Then FETCH.
  - LUI(10): alu_src_a=11, alu_src_b=01, imm_src=011, add. Then ALUWB.
  - HALT(15): halted=1, all enables 0. Stays until rst.
- Unused encodings 11–14 go to HALT on the next edge.

## Timing
- Reset: rst high forces state=FETCH asynchronously. While rst is high, pc_write, ir_write, reg_write, mem_req and mem_we are forced 0 and halted=0.
- First fetch request asserts in the first cycle after rst falls.
- Outputs are combinational from state. In FETCH, pc_write and ir_write also depend on mem_ready; in BRANCH, pc_write also depends on eq.
- mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE, and ignored elsewhere.
- While waiting on mem_ready, all outputs hold stable.
- Latency with mem_ready tied high:
  - R, I, lui, sw: 4 cycles.
  - lw: 5 cycles.
  - beq/bne: 3 cycles.
- Each memory wait cycle adds one cycle.
- Reset asserted mid-instruction aborts it; no write enable asserts after rst rises.

## Test plan
- Reset behaviour: rst pulse in MEMWRITE with mem_ready=0 -> state=0 immediately, mem_we=0; after release, mem_req=1 next cycle.
- addi, mem_ready=1: instr 0x00500093 -> states 0,1,7,8,0. reg_write=1 only in cycle 4; alu_src_b=01 in cycle 3.
- lw with 2 wait states: instr 0x0000A103, mem_ready low 2 cycles in MEMREAD -> 7 cycles total. reg_write=1 with result_src=01 exactly once.
- bne: instr 0xFE0098E3.
  - eq=0 -> pc_write=1 in BRANCH.
  - eq=1 -> pc_write=0.
  - Both cases return to FETCH after 3 cycles.
- sub vs add: instr 0x40208033 -> alu_ctrl=001 in EXEC_R; 0x00208033 -> alu_ctrl=000.
- Illegal opcode 0x0000007F -> HALT after DECODE, halted=1 with all enables 0 for 10+ cycles; rst returns the block to FETCH.
